// File: rtl/brush_stamper_pkg.sv
// rtl/brush_stamper_pkg.sv - shared canvas size, color codes and stamper state encoding
package brush_stamper_pkg;

  localparam int CANVAS = 128;

  typedef enum logic [2:0] {
    COLOR_BLACK   = 3'd0,
    COLOR_RED     = 3'd1,
    COLOR_GREEN   = 3'd2,
    COLOR_BLUE    = 3'd3,
    COLOR_YELLOW  = 3'd4,
    COLOR_CYAN    = 3'd5,
    COLOR_MAGENTA = 3'd6,
    COLOR_WHITE   = 3'd7
  } color_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PIX0,
    ST_PIX1,
    ST_DONE
  } stamp_state_t;

endpackage

// File: rtl/brush_stamper_clip.sv
// rtl/brush_stamper_clip.sv - combinational clipping of a square stamp against the canvas
module stamp_clip #(
  parameter int CANVAS = 128
) (
  input  logic [7:0] cx,
  input  logic [7:0] cy,
  input  logic [2:0] r,
  input  logic       clear,
  output logic [7:0] x0,
  output logic [7:0] x1,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic       empty
);

  localparam logic [8:0] LIMIT = 9'(CANVAS - 1);

  // 9-bit arithmetic: centre-minus-radius may go negative, centre-plus-radius may exceed 255
  function automatic logic [7:0] lo_clip(input logic [7:0] c, input logic [2:0] rr);
    logic [8:0] d;
    d = {1'b0, c} - {6'b0, rr};
    return d[8] ? 8'd0 : d[7:0];
  endfunction

  function automatic logic [7:0] hi_clip(input logic [7:0] c, input logic [2:0] rr);
    logic [8:0] s;
    s = {1'b0, c} + {6'b0, rr};
    return (s > LIMIT) ? LIMIT[7:0] : s[7:0];
  endfunction

  always_comb begin
    x0 = 8'd0;
    x1 = LIMIT[7:0];
    y0 = 8'd0;
    y1 = LIMIT[7:0];
    if (!clear) begin
      x0 = lo_clip(cx, r);
      x1 = hi_clip(cx, r);
      y0 = lo_clip(cy, r);
      y1 = hi_clip(cy, r);
    end
    empty = (x0 > x1) | (y0 > y1);
  end

endmodule

// File: rtl/brush_stamper.sv
// rtl/brush_stamper.sv - expands stamp/clear commands into two-cycle single-pixel store writes
module brush_stamper
  import brush_stamper_pkg::*;
#(
  parameter int CANVAS = brush_stamper_pkg::CANVAS,
  parameter int HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [2:0] cmd_radius,
  input  logic [2:0] cmd_color,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] newColor,
  output logic       brush,
  output logic       busy,
  output logic       done
);

  if (HOLD != 2 || CANVAS > 128 || (CANVAS & (CANVAS - 1)) != 0) begin : g_param_check
    $error("brush_stamper: HOLD must be 2 and CANVAS a power of two <= 128");
  end

  stamp_state_t state;

  logic [7:0] cx, cy;
  logic [2:0] cr;
  logic       cclear;
  color_t     ccolor;

  logic [7:0] bx0, bx1, by1;
  logic [7:0] clip_x0, clip_x1, clip_y0, clip_y1;
  logic       clip_empty;

  stamp_clip #(.CANVAS(CANVAS)) u_clip (
    .cx    (cx),
    .cy    (cy),
    .r     (cr),
    .clear (cclear),
    .x0    (clip_x0),
    .x1    (clip_x1),
    .y0    (clip_y0),
    .y1    (clip_y1),
    .empty (clip_empty)
  );

  // Ready is decoded from state so a held command is taken the first IDLE cycle
  assign cmd_ready = reset & (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      brush    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wx       <= 8'd0;
      wy       <= 8'd0;
      newColor <= 3'd0;
      cx       <= 8'd0;
      cy       <= 8'd0;
      cr       <= 3'd0;
      cclear   <= 1'b0;
      ccolor   <= COLOR_BLACK;
      bx0      <= 8'd0;
      bx1      <= 8'd0;
      by1      <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cx     <= cmd_x;
            cy     <= cmd_y;
            cr     <= cmd_radius;
            cclear <= cmd_clear;
            ccolor <= color_t'(cmd_color);
            busy   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          bx0 <= clip_x0;
          bx1 <= clip_x1;
          by1 <= clip_y1;
          if (clip_empty) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wx       <= clip_x0;
            wy       <= clip_y0;
            newColor <= ccolor;
            brush    <= 1'b1;
            state    <= ST_PIX0;
          end
        end
        ST_PIX0: begin
          state <= ST_PIX1;
        end
        ST_PIX1: begin
          if (wx < bx1) begin
            wx    <= wx + 8'd1;
            state <= ST_PIX0;
          end else if (wy < by1) begin
            wx    <= bx0;
            wy    <= wy + 8'd1;
            state <= ST_PIX0;
          end else begin
            brush <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          brush <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
